// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache with data priority.
// Optional anti-starvation streak counter is enabled by defining CACHE_ARB_FAIR_EN.
module cache_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DGNT = 2'b01,
        IGNT = 2'b10
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("cache_mem_arbiter: STARVE_LIMIT must be within 1..15");
    end

    state_t state_q, state_d;
    logic   arb_err_q, arb_err_d;
    logic   d_req;
    logic   ram_done;
    logic   ram_err;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
    assign ram_err  = (ramstate == RAM_ERROR);
    assign arb_err  = arb_err_q;

`ifdef CACHE_ARB_FAIR_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] streak_q, streak_d;

    // Counts data grants that bypassed a pending instruction request.
    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (!iREN || state_d == IGNT) begin
                streak_d = '0;
            end else if (state_d == DGNT && streak_q != LIMIT) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        arb_err_d = arb_err_q;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        unique case (state_q)
            IDLE: begin
`ifdef CACHE_ARB_FAIR_EN
                if (iREN && streak_q == LIMIT) begin
                    state_d = IGNT;
                end else
`endif
                if (d_req) begin
                    state_d = DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end
            DGNT: begin
                dload = ramload;
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ram_done) begin
                        dwait     = 1'b0;
                        state_d   = IDLE;
                        arb_err_d = arb_err_q | ram_err;
                    end
                end
            end
            IGNT: begin
                iload = ramload;
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_done) begin
                        iwait     = 1'b0;
                        state_d   = IDLE;
                        arb_err_d = arb_err_q | ram_err;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            arb_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arb_err_q <= arb_err_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: completions are checked by a scoreboard monitor,
// RAM control outputs by inline checks.
module tb_cache_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, arb_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_i;
        logic [31:0] load;
    } exp_t;

    exp_t sb[$];

    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;

    cache_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic is_i, input logic [31:0] load);
        exp_t e;
        e.is_i = is_i;
        e.load = load;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every wait pulse must match the next expected completion.
    always @(negedge CLK) begin
        if (nRST && (!iwait || !dwait)) begin
            exp_t e;
            chk("single_owner_pulse", {31'd0, iwait | dwait}, 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_completion", {31'd0, iwait}, {31'd0, dwait});
                errors++;
                $display("FAIL unexpected_completion: iwait=%b dwait=%b with empty queue", iwait, dwait);
            end else begin
                e = sb.pop_front();
                chk("completion_owner", {31'd0, !iwait}, {31'd0, e.is_i});
                chk("completion_load", e.is_i ? iload : dload, e.load);
            end
        end
    end

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        // Reset state
        @(negedge CLK);
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd1);
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_iload", iload, 32'd0);
        chk("rst_arb_err", {31'd0, arb_err}, 32'd0);
        nRST = 1'b1;
        step();

        // Single I read completing on the 3rd grant cycle
        iREN = 1; iaddr = 32'h40; ramstate = BUSY;
        step();
        for (int unsigned c = 1; c <= 3; c++) begin
            if (c == 3) begin
                ramstate = ACC; ramload = 32'h8C41_0004;
                push(1'b1, 32'h8C41_0004);
            end
            @(negedge CLK);
            chk("iread_ramREN", {31'd0, ramREN}, 32'd1);
            chk("iread_ramaddr", ramaddr, 32'h40);
            if (c < 3) chk("iread_iwait_high", {31'd0, iwait}, 32'd1);
            step();
        end
        // Back in IDLE: request still high but no strobe (bubble)
        chk("iread_bubble_ramREN", {31'd0, ramREN}, 32'd0);
        @(negedge CLK);
        iREN = 0; ramstate = FREE;
        step();

        // Simultaneous I read and D write, RAM completes immediately
        iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        ramstate = ACC; ramload = 32'h1111_1111;
        push(1'b0, 32'h1111_1111);
        push(1'b1, 32'h1111_1111);
        step();
        @(negedge CLK);
        chk("sim_ramWEN", {31'd0, ramWEN}, 32'd1);
        chk("sim_ramREN", {31'd0, ramREN}, 32'd0);
        chk("sim_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("sim_ramaddr", ramaddr, 32'h100);
        chk("sim_iwait_held", {31'd0, iwait}, 32'd1);
        step();
        dWEN = 0;
        @(negedge CLK);
        chk("sim_bubble_ramREN", {31'd0, ramREN}, 32'd0);
        chk("sim_bubble_ramWEN", {31'd0, ramWEN}, 32'd0);
        step();
        @(negedge CLK);
        chk("sim_i_ramREN", {31'd0, ramREN}, 32'd1);
        chk("sim_i_ramaddr", ramaddr, 32'h80);
        chk("sim_i_ramstore", ramstore, 32'd0);
        step();
        iREN = 0;

        // Error during IGNT, then 10 successful D reads
        step();
        iREN = 1; iaddr = 32'h200; ramstate = ERR; ramload = 32'h2222_2222;
        push(1'b1, 32'h2222_2222);
        step();
        @(negedge CLK);
        chk("err_pre_flag", {31'd0, arb_err}, 32'd0);
        step();
        iREN = 0; ramstate = ACC; dREN = 1; daddr = 32'h180;
        chk("err_flag_set", {31'd0, arb_err}, 32'd1);
        for (int unsigned k = 0; k < 10; k++) begin
            step();
            ramload = 32'h1000 + k;
            push(1'b0, 32'h1000 + k);
            @(negedge CLK);
            chk("err_dread_ramREN", {31'd0, ramREN}, 32'd1);
            step();
            if (k == 9) dREN = 0;
            chk("err_flag_sticky", {31'd0, arb_err}, 32'd1);
        end
        ramstate = FREE;
        step();

        // Withdrawal in the 2nd DGNT cycle
        dREN = 1; daddr = 32'h300; ramstate = BUSY;
        step();
        @(negedge CLK);
        chk("wd_c1_ramREN", {31'd0, ramREN}, 32'd1);
        chk("wd_c1_ramaddr", ramaddr, 32'h300);
        step();
        dREN = 0;
        #1;
        chk("wd_c2_ramREN", {31'd0, ramREN}, 32'd0);
        chk("wd_c2_dwait", {31'd0, dwait}, 32'd1);
        step();
        dREN = 1; ramstate = ACC;
        #1;
        chk("wd_idle_ramREN", {31'd0, ramREN}, 32'd0);
        dREN = 0;
        ramstate = FREE;
        step();

        // Contention with 1-cycle RAM: fairness pattern or strict data priority
        ramload = 32'h5555_AAAA;
        for (int unsigned g = 0; g < 10; g++) begin
`ifdef CACHE_ARB_FAIR_EN
            push((g % 5) == 4, 32'h5555_AAAA);
`else
            push(1'b0, 32'h5555_AAAA);
`endif
        end
        iREN = 1; dREN = 1; ramstate = ACC;
        for (int unsigned c = 0; c < 20; c++) step();
        iREN = 0; dREN = 0; ramstate = FREE;
        step();

        // Reset asserted mid-DGNT write
        dWEN = 1; daddr = 32'h400; dstore = 32'h1234_5678; ramstate = BUSY;
        step();
        chk("mid_pre_ramWEN", {31'd0, ramWEN}, 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("mid_rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("mid_rst_dwait", {31'd0, dwait}, 32'd1);
        chk("mid_rst_ramaddr", ramaddr, 32'd0);
        chk("mid_rst_arb_err", {31'd0, arb_err}, 32'd0);
        dWEN = 0; ramstate = FREE;
        @(negedge CLK);
        nRST = 1'b1;
        step();
        step();
        @(negedge CLK);
        chk("post_rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("post_rst_ramaddr", ramaddr, 32'd0);
        chk("post_rst_iwait", {31'd0, iwait}, 32'd1);
        chk("post_rst_dload", dload, 32'd0);

        // Bounded drain of the scoreboard
        for (int unsigned t = 0; t < 20 && sb.size() != 0; t++) step();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single RAM port between the instruction cache and the data cache. Each cache request is granted one at a time and held until RAM reports completion. The completion is then returned to the owning cache as a one-cycle deassertion of its wait signal. The block sits between the icache/dcache pair and the RAM model, and it owns every RAM control signal.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request is pending (fair mode only); range 1–15.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly the cycle the icache read completes.
- iload  out  32  instruction data; ramload while granted to I, else 0.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low for exactly the cycle the dcache access completes.
- dload  out  32  data; ramload while granted to D, else 0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
- arb_err  out  1  sticky; set when ramstate is ERROR during a grant.

## Operation
- State register values: IDLE, DGNT, IGNT.
- IDLE:
  - Drive no RAM strobes; iwait=dwait=1.
  - Pick the next state from the current requests.
  - dREN|dWEN → DGNT (data priority).
  - Else iREN → IGNT.
  - Else stay in IDLE.
- DGNT:
  - ramaddr=daddr.
  - If dWEN: ramWEN=1, ramREN=0, ramstore=dstore. dWEN wins when dREN and dWEN are both high.
  - Else: ramREN=1.
- IGNT: ramREN=1, ramaddr=iaddr, ramstore=0.
- Completion:
  - ramstate==ACCESS while granted → the owner's wait=0 that cycle.
  - The owner's load output is ramload that cycle.
  - Next state is IDLE.
- ERROR while granted: treated as completion (wait=0, next state IDLE), and arb_err is set. arb_err clears only on reset.
- FREE or BUSY while granted: hold the grant; all outputs stay stable.
- Request withdrawn while granted: the owner's request line goes low before ACCESS. RAM strobes drop in that same cycle (combinational), and the state returns to IDLE next cycle. No wait pulse is issued.
- The non-owner's wait is held at 1 for the whole grant, whatever it requests.
- After every completion, the block returns to IDLE for one cycle. Back-to-back requests from the same cache re-arbitrate there.
- Reset (asynchronous, any time, including mid-grant):
  - State goes to IDLE; iwait=dwait=1.
  - ramREN=ramWEN=0; ramaddr=ramstore=0; iload=dload=0.
  - arb_err=0; streak counter=0.
  - Any RAM transaction in flight is abandoned.

## Timing
- Request sampled in IDLE at edge t → grant and RAM strobes valid in cycle t+1.
- ACCESS in cycle t+1 → wait low in t+1; IDLE in t+2.
- Minimum access: 2 cycles from request to completion.
- Back-to-back accesses from one cache: 1 bubble cycle each.
- All RAM outputs are combinational from the state and the granted requester's inputs. The state and counter are the only flops, plus arb_err.

## Configuration
- CACHE_ARB_FAIR_EN defined: adds a 4-bit streak counter.
  - Incremented on each IDLE→DGNT transition taken while iREN=1, saturating at STARVE_LIMIT.
  - Cleared on IDLE→IGNT, and in any IDLE cycle with iREN=0.
  - In IDLE, when the counter equals STARVE_LIMIT and iREN=1, the block goes to IGNT even if D is requesting.
- CACHE_ARB_FAIR_EN undefined: strict data priority; no counter logic.

## Test plan
- Reset and idle: assert nRST low mid-DGNT with dWEN=1 → that same cycle ramWEN=0, dwait=1, ramaddr=0. After release with no requests, outputs stay at reset values.
- Single I read: iREN=1, iaddr=0x40, ramstate ACCESS on the 3rd grant cycle, ramload=0x8C410004.
  - Required: ramREN=1 and ramaddr=0x40 for 3 cycles.
  - iwait low only in the 3rd cycle, with iload=0x8C410004.
  - State back to IDLE the next cycle.
- Simultaneous request: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF), RAM completing immediately.
  - D is served first: ramWEN=1, ramstore=0xDEADBEEF, dwait pulse.
  - After 1 IDLE bubble, I is served.
  - iwait stays 1 throughout the D grant.
- Error: during IGNT, ramstate=11 → iwait=0 that cycle, arb_err=1 and stays set through 10 further successful accesses.
- Withdrawal: dREN drops in the 2nd DGNT cycle before ACCESS → ramREN=0 that cycle, no dwait pulse, IDLE next cycle.
- Fairness (CACHE_ARB_FAIR_EN, STARVE_LIMIT=4): iREN and dREN held high continuously, 1-cycle RAM → grants alternate as D,D,D,D,I,D,D,D,D,I. Without the macro, I is never granted.
